i2c_target_byte: RTL and testbench
==================================

# i2c_target_byte

I2C responder (target) that sits at the far end of the bus from the team's I2C master and its `i2c_bit_timer`-paced SCL generator. It samples raw SCL/SDA on the system clock, filters glitches, and detects START/STOP. It matches a fixed 7-bit address, receives write bytes into a parallel port with a valid strobe, and serves read bytes from a parallel port with a load strobe. SDA is driven open-drain through an output-enable.

## Interface
- `ADDR`, 7'h42, 7-bit target address; general call (0x00) is not supported and gets a NACK.
- `FILTER`, 3, number of consecutive equal synchronized samples required before a filtered line changes; must be ≥1.
- `Clk`  in  1  system clock; all logic on its rising edge.
- `Rst`  in  1  reset, synchronous, active-high.
- `Scl`  in  1  raw SCL line (asynchronous).
- `Sda_in`  in  1  raw SDA line (asynchronous).
- `Sda_oe`  out  1  1 = pull SDA low, 0 = release.
- `Rx_data`  out  8  last received write byte.
- `Rx_valid`  out  1  one-cycle pulse when `Rx_data` is updated.
- `Tx_data`  in  8  next read byte; producer holds it stable until `Tx_load`.
- `Tx_load`  out  1  one-cycle pulse in the cycle `Tx_data` is captured; producer may change `Tx_data` on the following cycle.
- `Rw`  out  1  R/W bit of the last matched address byte (1 = read).
- `Busy`  out  1  high from address match until STOP, repeated START, NACK, or reset.

## Operation
- Line conditioning:
  - Each line goes through a 2-flop synchronizer, then the FILTER glitch filter, giving `scl_f` and `sda_f`.
  - Derived one-cycle events:
    - `scl_rise`, `scl_fall`
    - `start` = `sda_f` falls while `scl_f` = 1
    - `stop` = `sda_f` rises while `scl_f` = 1
- States: IDLE, ADDR, ADDR_ACK, RX, RX_ACK, TX, TX_ACK, WAIT_STOP.
- Priority:
  - `stop` beats `start`, and both beat SCL edges in the same cycle.
  - `start` from any state goes to ADDR: bit counter 0, `Sda_oe` = 0, `Busy` = 0.
  - `stop` from any state goes to IDLE: `Sda_oe` = 0, `Busy` = 0.
- ADDR:
  - Shift `sda_f` MSB-first on each `scl_rise`.
  - After the 8th rise, if bits[7:1] == ADDR: set `Rw` = bit0, `Busy` = 1, then go to ADDR_ACK at the next `scl_fall` with `Sda_oe` = 1.
  - Otherwise go to WAIT_STOP.
- ADDR_ACK, at the next `scl_fall`:
  - `Rw` = 0: release SDA, go to RX.
  - `Rw` = 1: capture `Tx_data`, pulse `Tx_load`, set `Sda_oe` = ~`Tx_data`[7], go to TX.
- RX:
  - Sample on `scl_rise`.
  - After the 8th bit, update `Rx_data` and pulse `Rx_valid` in the cycle after that rise.
  - Next `scl_fall`: `Sda_oe` = 1, go to RX_ACK.
  - Following `scl_fall`: release, go back to RX.
  - Every received byte is ACKed; there is no back-pressure.
- TX:
  - On each `scl_fall`, present the next bit MSB-first.
  - On the `scl_fall` after bit 0, release SDA and go to TX_ACK.
- TX_ACK, sample `sda_f` at `scl_rise`:
  - 0 (ACK): at the next `scl_fall`, capture `Tx_data`, pulse `Tx_load`, drive its bit 7, go to TX.
  - 1 (NACK): go to WAIT_STOP with SDA released.
- WAIT_STOP: `Sda_oe` = 0. Ignore everything except `start` and `stop`.
- The target never stretches SCL.

## Timing
- Reset values:
  - All outputs 0; state IDLE.
  - Synchronizer and filter registers preset to 1 (idle bus), so no spurious `start` or `stop` follows reset.
- Event latency: filtered signals and events lag the raw lines by 2 + FILTER `Clk` cycles.
- `Sda_oe` changes exactly 1 cycle after the `scl_fall` event; it never changes while `scl_f` = 1, so the target cannot create a false START or STOP.
- Legal operation requires SCL high and low phases of at least FILTER + 6 `Clk` cycles.
- Reset mid-transfer: `Sda_oe` = 0 in the cycle after `Rst`. The target stays IDLE until the next `start`; a STOP is not required.

## Structure
- Package `i2c_pkg`:
  - state enum
  - `ACK` = 1'b0, `NACK` = 1'b1
  - `I2C_ADDR_W` = 7, `I2C_BYTE_W` = 8
- Sub-module `i2c_line_filter`:
  - synchronizer + FILTER counter + rise/fall detect
  - instantiated once for SCL and once for SDA
- The top level holds the FSM, the bit counter (0–8), and the shift registers.

## Test plan
- Reset, then Scl = Sda_in = 1 for 50 cycles -> `Sda_oe`, `Busy`, `Rx_valid`, `Tx_load` all stay 0.
- START, byte 0x84, data 0xA5, STOP:
  - `Sda_oe` = 1 during the 9th SCL of each byte.
  - `Rx_data` = 0xA5 with a single `Rx_valid` pulse.
  - `Busy` falls after STOP.
- START, byte 0x86 (address 0x43), data 0xFF -> `Sda_oe` stays 0 throughout, no `Rx_valid`, `Busy` = 0.
- Read from 0x85 with `Tx_data` = 0x3C then 0xF0, master ACKs the first byte and NACKs the second:
  - SDA shows 0x3C then 0xF0.
  - Exactly two `Tx_load` pulses.
  - SDA released after the NACK, state WAIT_STOP until STOP.
- Write 0x84/0x11, repeated START, then 0x85 read:
  - `Rx_valid` once with 0x11.
  - `Rw` goes 0 -> 1.
  - `Tx_load` at the address ACK end, no intervening STOP needed.
- Glitches and reset:
  - A 1-cycle SCL low glitch with FILTER = 3 during RX -> no extra bit shifted, received byte correct.
  - `Rst` asserted while `Sda_oe` = 1 in TX -> `Sda_oe` = 0 next cycle; following SCL pulses are ignored until a new START.

Source files
------------

// File: rtl/i2c_pkg.sv
// rtl/i2c_pkg.sv - shared types and constants for the I2C byte-level target
//
// Purpose: FSM state encoding, ACK/NACK bus levels and field widths used by
// the target top level, its line filter and its bus interface.
// Ports: none (package).

package i2c_pkg;

  localparam int I2C_ADDR_W = 7;
  localparam int I2C_BYTE_W = 8;

  // Level seen on SDA during the ninth clock of a byte.
  localparam logic ACK  = 1'b0;
  localparam logic NACK = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_RX,
    ST_RX_ACK,
    ST_TX,
    ST_TX_ACK,
    ST_WAIT_STOP
  } i2c_state_e;

endpackage

// File: rtl/i2c_target_byte_if.sv
// rtl/i2c_target_byte_if.sv - bus and byte-port bundle for the I2C target
//
// Purpose: groups the raw I2C lines and the parallel byte ports so the
// target and its environment connect through one port.
// Signals:
//   Scl, Sda_in  raw asynchronous bus lines into the target
//   Sda_oe       1 = target pulls SDA low (open drain)
//   Rx_data      last received write byte, Rx_valid one-cycle update strobe
//   Tx_data      next read byte, Tx_load one-cycle capture strobe
//   Rw           R/W bit of the last matched address byte
//   Busy         target is addressed and active
// Modports: slave = the target, master = the environment driving the bus.

interface i2c_target_byte_if;
  import i2c_pkg::*;

  logic                  Scl;
  logic                  Sda_in;
  logic                  Sda_oe;
  logic [I2C_BYTE_W-1:0] Rx_data;
  logic                  Rx_valid;
  logic [I2C_BYTE_W-1:0] Tx_data;
  logic                  Tx_load;
  logic                  Rw;
  logic                  Busy;

  modport slave (
    input  Scl, Sda_in, Tx_data,
    output Sda_oe, Rx_data, Rx_valid, Tx_load, Rw, Busy
  );

  modport master (
    output Scl, Sda_in, Tx_data,
    input  Sda_oe, Rx_data, Rx_valid, Tx_load, Rw, Busy
  );

endinterface

// File: rtl/i2c_line_filter.sv
// rtl/i2c_line_filter.sv - synchronizer, glitch filter and edge detect for one I2C line
//
// Purpose: brings an asynchronous bus line into the Clk domain, suppresses
// pulses shorter than FILTER cycles and flags the filtered edges.
// Ports:
//   Clk     system clock
//   Rst     synchronous active-high reset (line state presets to idle-high)
//   line_i  raw asynchronous line
//   line_o  filtered line
//   rise_o  one-cycle pulse in the first cycle line_o is high after being low
//   fall_o  one-cycle pulse in the first cycle line_o is low after being high

module i2c_line_filter #(
  parameter int FILTER = 3
) (
  input  logic Clk,
  input  logic Rst,
  input  logic line_i,
  output logic line_o,
  output logic rise_o,
  output logic fall_o
);

  localparam int CW = (FILTER < 2) ? 1 : $clog2(FILTER);

  logic [1:0]    sync_q;
  logic          filt_q, filt_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          rise_q, rise_d;
  logic          fall_q, fall_d;
  logic          sync_s;

  assign sync_s = sync_q[1];

  // The filtered line only follows the synchronized line once it has
  // disagreed for FILTER consecutive cycles; any agreement restarts the count.
  always_comb begin
    filt_d = filt_q;
    cnt_d  = cnt_q;
    rise_d = 1'b0;
    fall_d = 1'b0;
    if (sync_s == filt_q) begin
      cnt_d = '0;
    end else if (cnt_q == CW'(FILTER - 1)) begin
      filt_d = sync_s;
      cnt_d  = '0;
      rise_d = sync_s;
      fall_d = ~sync_s;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      sync_q <= 2'b11;
      filt_q <= 1'b1;
      cnt_q  <= '0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], line_i};
      filt_q <= filt_d;
      cnt_q  <= cnt_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign line_o = filt_q;
  assign rise_o = rise_q;
  assign fall_o = fall_q;

endmodule

// File: rtl/i2c_target_byte.sv
// rtl/i2c_target_byte.sv - I2C target with fixed address and parallel byte ports
//
// Purpose: detects START/STOP on filtered SCL/SDA, matches a 7-bit address,
// receives write bytes onto Rx_data/Rx_valid and serves read bytes from
// Tx_data/Tx_load, driving SDA open-drain. Never stretches SCL.
// Parameters: ADDR target address, FILTER glitch filter length (>= 1).
// Ports:
//   Clk  system clock
//   Rst  synchronous active-high reset
//   bus  i2c_target_byte_if.slave (lines, byte ports, Rw, Busy)

module i2c_target_byte
  import i2c_pkg::*;
#(
  parameter logic [I2C_ADDR_W-1:0] ADDR   = 7'h42,
  parameter int                    FILTER = 3
) (
  input  logic                Clk,
  input  logic                Rst,
  i2c_target_byte_if.slave    bus
);

  logic scl_f, scl_rise, scl_fall;
  logic sda_f, sda_rise, sda_fall;
  logic start_ev, stop_ev;

  i2c_line_filter #(.FILTER(FILTER)) u_scl_filter (
    .Clk    (Clk),
    .Rst    (Rst),
    .line_i (bus.Scl),
    .line_o (scl_f),
    .rise_o (scl_rise),
    .fall_o (scl_fall)
  );

  i2c_line_filter #(.FILTER(FILTER)) u_sda_filter (
    .Clk    (Clk),
    .Rst    (Rst),
    .line_i (bus.Sda_in),
    .line_o (sda_f),
    .rise_o (sda_rise),
    .fall_o (sda_fall)
  );

  assign start_ev = sda_fall & scl_f;
  assign stop_ev  = sda_rise & scl_f;

  i2c_state_e            state_q, state_d;
  logic [3:0]            bit_cnt_q, bit_cnt_d;
  logic [I2C_BYTE_W-2:0] shift_q, shift_d;     // bits received so far, newest in [0]
  logic [I2C_BYTE_W-2:0] tx_shift_q, tx_shift_d; // bits of the read byte still to send
  logic                  sda_oe_q, sda_oe_d;
  logic [I2C_BYTE_W-1:0] rx_data_q, rx_data_d;
  logic                  rx_valid_q, rx_valid_d;
  logic                  rw_q, rw_d;
  logic                  busy_q, busy_d;
  logic                  tx_load;
  logic [I2C_BYTE_W-1:0] rx_byte;

  // Byte as it stands once the bit currently on SDA is shifted in.
  assign rx_byte = {shift_q, sda_f};

  // All SDA drive changes are made on a filtered SCL fall, so Sda_oe only
  // moves while SCL is low and the target can never fake START or STOP.
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    tx_shift_d = tx_shift_q;
    sda_oe_d   = sda_oe_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    rw_d       = rw_q;
    busy_d     = busy_q;
    tx_load    = 1'b0;

    if (stop_ev) begin
      state_d   = ST_IDLE;
      bit_cnt_d = 4'd0;
      sda_oe_d  = 1'b0;
      busy_d    = 1'b0;
    end else if (start_ev) begin
      state_d   = ST_ADDR;
      bit_cnt_d = 4'd0;
      sda_oe_d  = 1'b0;
      busy_d    = 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE, ST_WAIT_STOP: begin
          sda_oe_d = 1'b0;
        end

        // bit_cnt_q == 8 here means the address matched and the ACK is
        // pending the next SCL fall.
        ST_ADDR: begin
          if (scl_rise && bit_cnt_q < 4'd8) begin
            shift_d   = rx_byte[I2C_BYTE_W-2:0];
            bit_cnt_d = bit_cnt_q + 4'd1;
            if (bit_cnt_q == 4'd7) begin
              if (rx_byte[I2C_BYTE_W-1:1] == ADDR) begin
                rw_d   = rx_byte[0];
                busy_d = 1'b1;
              end else begin
                state_d = ST_WAIT_STOP;
              end
            end
          end else if (scl_fall && bit_cnt_q == 4'd8) begin
            sda_oe_d = 1'b1;
            state_d  = ST_ADDR_ACK;
          end
        end

        ST_ADDR_ACK: begin
          if (scl_fall) begin
            if (!rw_q) begin
              sda_oe_d  = 1'b0;
              bit_cnt_d = 4'd0;
              state_d   = ST_RX;
            end else begin
              tx_load    = 1'b1;
              tx_shift_d = bus.Tx_data[I2C_BYTE_W-2:0];
              sda_oe_d   = ~bus.Tx_data[I2C_BYTE_W-1];
              bit_cnt_d  = 4'd1;
              state_d    = ST_TX;
            end
          end
        end

        ST_RX: begin
          if (scl_rise && bit_cnt_q < 4'd8) begin
            shift_d   = rx_byte[I2C_BYTE_W-2:0];
            bit_cnt_d = bit_cnt_q + 4'd1;
            if (bit_cnt_q == 4'd7) begin
              rx_data_d  = rx_byte;
              rx_valid_d = 1'b1;
            end
          end else if (scl_fall && bit_cnt_q == 4'd8) begin
            sda_oe_d = 1'b1;
            state_d  = ST_RX_ACK;
          end
        end

        ST_RX_ACK: begin
          if (scl_fall) begin
            sda_oe_d  = 1'b0;
            bit_cnt_d = 4'd0;
            state_d   = ST_RX;
          end
        end

        // bit_cnt_q counts bits already placed on SDA; bit 7 went out on entry.
        ST_TX: begin
          if (scl_fall) begin
            if (bit_cnt_q == 4'd8) begin
              sda_oe_d = 1'b0;
              state_d  = ST_TX_ACK;
            end else begin
              sda_oe_d   = ~tx_shift_q[I2C_BYTE_W-2];
              tx_shift_d = {tx_shift_q[I2C_BYTE_W-3:0], 1'b0};
              bit_cnt_d  = bit_cnt_q + 4'd1;
            end
          end
        end

        // A NACK leaves on the rise, so reaching the fall implies an ACK.
        ST_TX_ACK: begin
          if (scl_rise && sda_f == NACK) begin
            state_d = ST_WAIT_STOP;
            busy_d  = 1'b0;
          end else if (scl_fall) begin
            tx_load    = 1'b1;
            tx_shift_d = bus.Tx_data[I2C_BYTE_W-2:0];
            sda_oe_d   = ~bus.Tx_data[I2C_BYTE_W-1];
            bit_cnt_d  = 4'd1;
            state_d    = ST_TX;
          end
        end

        default: begin
          state_d  = ST_IDLE;
          sda_oe_d = 1'b0;
          busy_d   = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q    <= ST_IDLE;
      bit_cnt_q  <= 4'd0;
      shift_q    <= '0;
      tx_shift_q <= '0;
      sda_oe_q   <= 1'b0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      rw_q       <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      tx_shift_q <= tx_shift_d;
      sda_oe_q   <= sda_oe_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      rw_q       <= rw_d;
      busy_q     <= busy_d;
    end
  end

  assign bus.Sda_oe   = sda_oe_q;
  assign bus.Rx_data  = rx_data_q;
  assign bus.Rx_valid = rx_valid_q;
  assign bus.Tx_load  = tx_load;
  assign bus.Rw       = rw_q;
  assign bus.Busy     = busy_q;

endmodule

// File: tb/tb_i2c_target_byte.sv
// tb/tb_i2c_target_byte.sv - directed self-checking bench for i2c_target_byte

module tb_i2c_target_byte;
  import i2c_pkg::*;

  localparam int Q = 10;
  localparam int H = 20;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic scl = 1'b1;
  logic sda_m = 1'b1;
  logic bus_sda;

  int checks = 0;
  int errors = 0;
  int rx_cnt = 0;
  int tx_cnt = 0;
  int oe_cyc = 0;
  logic [7:0] rx_last = 8'h00;

  i2c_target_byte_if bus ();

  assign bus_sda    = sda_m & ~bus.Sda_oe;
  assign bus.Scl    = scl;
  assign bus.Sda_in = bus_sda;

  i2c_target_byte #(.ADDR(7'h42), .FILTER(3)) dut (
    .Clk (clk),
    .Rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.Rx_valid === 1'b1) begin
      rx_cnt  = rx_cnt + 1;
      rx_last = bus.Rx_data;
    end
    if (bus.Tx_load === 1'b1) tx_cnt = tx_cnt + 1;
    if (bus.Sda_oe === 1'b1) oe_cyc = oe_cyc + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One SCL clock with SDA driven to b; returns bus SDA and Sda_oe mid-high.
  task automatic clk_bit(input logic b, input bit glitch, output logic smp, output logic oe);
    sda_m = b;
    cyc(Q);
    scl = 1'b1;
    cyc(5);
    if (glitch) begin
      scl = 1'b0;
      cyc(1);
      scl = 1'b1;
      cyc(4);
    end else begin
      cyc(5);
    end
    smp = bus_sda;
    oe  = bus.Sda_oe;
    cyc(H - 10);
    scl = 1'b0;
    cyc(Q);
  endtask

  task automatic i2c_start();
    sda_m = 1'b1;
    cyc(Q);
    scl = 1'b1;
    cyc(H);
    sda_m = 1'b0;
    cyc(H);
    scl = 1'b0;
    cyc(Q);
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0;
    cyc(Q);
    scl = 1'b1;
    cyc(H);
    sda_m = 1'b1;
    cyc(H);
  endtask

  task automatic write_byte(input logic [7:0] d, input int gl_bit, output logic ack, output logic oe9);
    logic s, o;
    for (int i = 7; i >= 0; i--) clk_bit(d[i], (i == gl_bit), s, o);
    clk_bit(1'b1, 1'b0, ack, oe9);
  endtask

  task automatic read_bits(output logic [7:0] d);
    logic s, o;
    for (int i = 7; i >= 0; i--) begin
      clk_bit(1'b1, 1'b0, s, o);
      d[i] = s;
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    logic ack, oe9, s, o;
    logic [7:0] rd;
    int rx0, tx0, oe0;

    bus.Tx_data = 8'h00;
    rst = 1'b1;
    cyc(4);
    rst = 1'b0;
    cyc(1);
    chk("rst_oe", 32'(bus.Sda_oe), 32'd0);
    chk("rst_busy", 32'(bus.Busy), 32'd0);
    chk("rst_rw", 32'(bus.Rw), 32'd0);
    chk("rst_rxdata", 32'(bus.Rx_data), 32'h00);

    // Idle bus
    rx0 = rx_cnt; tx0 = tx_cnt; oe0 = oe_cyc;
    cyc(50);
    chk("idle_oe", 32'(oe_cyc - oe0), 32'd0);
    chk("idle_rx", 32'(rx_cnt - rx0), 32'd0);
    chk("idle_tx", 32'(tx_cnt - tx0), 32'd0);
    chk("idle_busy", 32'(bus.Busy), 32'd0);

    // Write 0xA5 to 0x42
    rx0 = rx_cnt;
    i2c_start();
    write_byte(8'h84, -1, ack, oe9);
    chk("wr_addr_ack", 32'(ack), 32'(ACK));
    chk("wr_addr_oe9", 32'(oe9), 32'd1);
    chk("wr_rw", 32'(bus.Rw), 32'd0);
    write_byte(8'hA5, -1, ack, oe9);
    chk("wr_data_ack", 32'(ack), 32'(ACK));
    chk("wr_data_oe9", 32'(oe9), 32'd1);
    chk("wr_rx_cnt", 32'(rx_cnt - rx0), 32'd1);
    chk("wr_rx_data", 32'(rx_last), 32'hA5);
    chk("wr_busy", 32'(bus.Busy), 32'd1);
    i2c_stop();
    chk("wr_busy_stop", 32'(bus.Busy), 32'd0);

    // Wrong address 0x43
    rx0 = rx_cnt; oe0 = oe_cyc;
    i2c_start();
    write_byte(8'h86, -1, ack, oe9);
    chk("na_addr_ack", 32'(ack), 32'(NACK));
    write_byte(8'hFF, -1, ack, oe9);
    chk("na_data_ack", 32'(ack), 32'(NACK));
    chk("na_oe", 32'(oe_cyc - oe0), 32'd0);
    chk("na_rx", 32'(rx_cnt - rx0), 32'd0);
    chk("na_busy", 32'(bus.Busy), 32'd0);
    i2c_stop();

    // Read two bytes, ACK then NACK
    tx0 = tx_cnt;
    bus.Tx_data = 8'h3C;
    i2c_start();
    write_byte(8'h85, -1, ack, oe9);
    chk("rd_addr_ack", 32'(ack), 32'(ACK));
    chk("rd_rw", 32'(bus.Rw), 32'd1);
    read_bits(rd);
    chk("rd_byte0", 32'(rd), 32'h3C);
    bus.Tx_data = 8'hF0;
    clk_bit(ACK, 1'b0, s, o);
    read_bits(rd);
    chk("rd_byte1", 32'(rd), 32'hF0);
    clk_bit(NACK, 1'b0, s, o);
    chk("rd_tx_loads", 32'(tx_cnt - tx0), 32'd2);
    chk("rd_oe_nack", 32'(bus.Sda_oe), 32'd0);
    chk("rd_busy_nack", 32'(bus.Busy), 32'd0);
    chk("rd_state_wait", 32'(dut.state_q), 32'(ST_WAIT_STOP));
    i2c_stop();
    chk("rd_state_idle", 32'(dut.state_q), 32'(ST_IDLE));

    // Write then repeated START into a read
    rx0 = rx_cnt; tx0 = tx_cnt;
    i2c_start();
    write_byte(8'h84, -1, ack, oe9);
    write_byte(8'h11, -1, ack, oe9);
    chk("rs_rx_cnt", 32'(rx_cnt - rx0), 32'd1);
    chk("rs_rx_data", 32'(rx_last), 32'h11);
    chk("rs_rw0", 32'(bus.Rw), 32'd0);
    bus.Tx_data = 8'h5A;
    i2c_start();
    write_byte(8'h85, -1, ack, oe9);
    chk("rs_addr_ack", 32'(ack), 32'(ACK));
    chk("rs_rw1", 32'(bus.Rw), 32'd1);
    chk("rs_tx_load", 32'(tx_cnt - tx0), 32'd1);
    read_bits(rd);
    chk("rs_rd", 32'(rd), 32'h5A);
    clk_bit(NACK, 1'b0, s, o);
    i2c_stop();

    // SCL glitch during a write byte
    rx0 = rx_cnt;
    i2c_start();
    write_byte(8'h84, -1, ack, oe9);
    write_byte(8'h3C, 3, ack, oe9);
    chk("gl_ack", 32'(ack), 32'(ACK));
    chk("gl_rx_cnt", 32'(rx_cnt - rx0), 32'd1);
    chk("gl_rx_data", 32'(rx_last), 32'h3C);
    i2c_stop();

    // Reset while driving a zero bit in TX
    bus.Tx_data = 8'h00;
    i2c_start();
    write_byte(8'h85, -1, ack, oe9);
    chk("rt_oe_tx", 32'(bus.Sda_oe), 32'd1);
    rst = 1'b1;
    cyc(1);
    chk("rt_oe_rst", 32'(bus.Sda_oe), 32'd0);
    rst = 1'b0;
    tx0 = tx_cnt; oe0 = oe_cyc; rx0 = rx_cnt;
    for (int i = 0; i < 9; i++) clk_bit(1'b1, 1'b0, s, o);
    chk("rt_oe_after", 32'(oe_cyc - oe0), 32'd0);
    chk("rt_tx_after", 32'(tx_cnt - tx0), 32'd0);
    chk("rt_busy", 32'(bus.Busy), 32'd0);
    chk("rt_state", 32'(dut.state_q), 32'(ST_IDLE));
    i2c_stop();

    // Recovery after reset
    i2c_start();
    write_byte(8'h84, -1, ack, oe9);
    write_byte(8'h77, -1, ack, oe9);
    chk("rc_rx_cnt", 32'(rx_cnt - rx0), 32'd1);
    chk("rc_rx_data", 32'(rx_last), 32'h77);
    i2c_stop();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
